card_dealer: RTL and testbench
==============================

Name: card_dealer

Overview:
Random card source for the BlackJack datapath. It sits directly downstream of the free-running player-timing counter and latches that counter's value as an entropy seed. Each deal request returns one card from a 52-card deck, without replacement, to the game FSM. Draws use a Galois LFSR with a bounded-latency fallback scan.

Parameters:
WIDTH, 12, width of i_Seed; must match the upstream counter width; WIDTH <= LFSR_W.
LFSR_W, 16, LFSR width; fixed at 16 for the polynomial below.
MAX_TRIES, 32, number of rejected LFSR draws before the linear-scan fallback engages.

Ports:
clk_50M  input  1  50 MHz system clock.
i_RstCounter  input  1  reset; asynchronous, active-high.
i_Seed  input  WIDTH  seed value from the upstream counter.
i_LoadSeed  input  1  one-cycle pulse; loads i_Seed into the LFSR.
i_Shuffle  input  1  one-cycle pulse; refills the deck to 52 cards.
i_DealReq  input  1  one-cycle pulse; requests one card.
o_Card  output  4  dealt card value; held until the next deal.
o_CardValid  output  1  one-cycle pulse; o_Card is updated in the same cycle.
o_Busy  output  1  high while a deal is in progress.
o_DeckEmpty  output  1  high when o_CardsLeft == 0.
o_CardsLeft  output  6  remaining cards, 0..52.

Behaviour:
- Reset values (asynchronous): LFSR = 16'hACE1, all 13 rank counts = 4, o_CardsLeft = 52, o_Card = 0, o_CardValid = 0, o_Busy = 0, o_DeckEmpty = 0, FSM = IDLE.
- LFSR:
  - Galois, right-shift, taps 16'hB400 (x^16+x^14+x^13+x^11+1).
  - Advances exactly one step per DRAW cycle and never otherwise.
- Seed load: LFSR <= zero_ext(i_Seed) ^ 16'hACE1. If that result is 0, load 16'hACE1 instead.
- FSM states: IDLE, DRAW, SCAN, EMIT.
- IDLE:
  - i_DealReq with o_DeckEmpty = 0 -> DRAW; o_Busy = 1 from the next cycle.
  - i_DealReq while the deck is empty is ignored, with no pulse.
- DRAW:
  - Candidate r = next_lfsr[3:0].
  - If 1 <= r <= 13 and count[r] > 0: latch r, decrement count[r] -> EMIT.
  - Otherwise increment the try counter.
  - When the try counter reaches MAX_TRIES -> SCAN, with the scan index = (r mod 13) + 1.
- SCAN:
  - Tests count[idx] each cycle. Accepts the first idx with count > 0, decrements it -> EMIT.
  - Otherwise idx wraps 13 -> 1.
  - Scan length is at most 13 cycles, and termination is guaranteed because the deck is non-empty.
- EMIT:
  - o_Card <= mapped rank, o_CardValid = 1 for one cycle, o_CardsLeft decrements, o_Busy = 0 -> IDLE.
- Latency: best case, o_CardValid is asserted 2 cycles after the i_DealReq edge. Worst case is 2 + MAX_TRIES + 13 cycles.
- o_DeckEmpty is registered and updates in the same cycle as the o_CardsLeft decrement.
- Priority when pulses coincide in one cycle: i_Shuffle > i_LoadSeed > i_DealReq.
  - i_Shuffle in IDLE: counts refill to 4 and o_CardsLeft = 52; a simultaneous i_DealReq is dropped.
  - i_LoadSeed in IDLE: the seed loads; a simultaneous i_DealReq is dropped.
- While o_Busy is high: i_DealReq, i_LoadSeed and i_Shuffle are all ignored; requests are not queued.
- Reset mid-deal: immediate return to the reset values; no o_CardValid pulse; a partial decrement is discarded because counts reset.
- Width rules:
  - Rank counts are 3 bits each.
  - o_CardsLeft is 6 bits and never underflows, because a deal is accepted only when the deck is non-empty.

Optional Feature:
FACE_AS_TEN_EN:
- Defined: EMIT maps ranks 11, 12, 13 to o_Card = 10 (blackjack value). Ace stays 1; deck bookkeeping still uses the true rank.
- Undefined: o_Card = raw rank, 1..13.

Decomposition:
- Package card_pkg: RANK_MIN = 1, RANK_MAX = 13, CARDS_PER_RANK = 4, DECK_SIZE = 52, LFSR_TAPS = 16'hB400, LFSR_DEFAULT = 16'hACE1, FSM state encoding, rank-to-value function.
- Sub-module card_lfsr: step enable, load enable, load value, state output, including the zero-guard. The dealer FSM and rank counts stay in card_dealer.

Test Plan:
- Reset then idle for 10 cycles -> o_CardsLeft = 52, o_DeckEmpty = 0, o_CardValid = 0, o_Busy = 0.
- Load seed 12'h5A3 then 52 deals -> 52 pulses, each rank exactly 4 times, o_DeckEmpty = 1 after the 52nd; a 53rd request gives no pulse and o_Busy stays 0.
- Load 12'h5A3, 5 deals, reset, reload 12'h5A3, 5 deals -> identical o_Card sequences.
- Load seed 12'h000 vs the reset default -> identical sequences; the LFSR is never zero.
- i_DealReq pulse, then a second i_DealReq while o_Busy = 1 -> exactly one o_CardValid; assert reset during DRAW -> no pulse, o_CardsLeft = 52.
- Deal until 1 card remains, then one deal -> pulse within 2 + MAX_TRIES + 13 cycles, o_DeckEmpty = 1; i_Shuffle -> o_CardsLeft = 52, o_DeckEmpty = 0.

Source files
------------

// File: rtl/card_pkg.sv
// Shared constants, FSM encoding and helpers for the card dealer.
// FACE_AS_TEN_EN: when defined, face cards are reported with value 10.
package card_pkg;

    localparam int RANK_MIN       = 1;
    localparam int RANK_MAX       = 13;
    localparam int CARDS_PER_RANK = 4;
    localparam int DECK_SIZE      = 52;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_SCAN,
        ST_EMIT
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_TAPS;
        end
        return n;
    endfunction

    // Candidate rank is the low nibble of the state after one step.
    function automatic logic [3:0] next_cand(input logic [15:0] s);
        logic [15:0] n;
        n = lfsr_step(s);
        return n[3:0];
    endfunction

    function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
`ifdef FACE_AS_TEN_EN
        return (rank > 4'd10) ? 4'd10 : rank;
`else
        return rank;
`endif
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// 16-bit Galois LFSR with seed load; a zero load value falls back
// to the default state so the register can never lock up.
module card_lfsr
    import card_pkg::*;
#(
    parameter int LFSR_W = 16
) (
    input  logic              clk_50M,
    input  logic              i_RstCounter,
    input  logic              i_Step,
    input  logic              i_Load,
    input  logic [LFSR_W-1:0] i_LoadVal,
    output logic [LFSR_W-1:0] o_State
);

    logic [LFSR_W-1:0] r_State;

    always_ff @(posedge clk_50M or posedge i_RstCounter) begin
        if (i_RstCounter) begin
            r_State <= LFSR_DEFAULT;
        end else if (i_Load) begin
            if (i_LoadVal == '0) begin
                r_State <= LFSR_DEFAULT;
            end else begin
                r_State <= i_LoadVal;
            end
        end else if (i_Step) begin
            r_State <= lfsr_step(r_State);
        end
    end

    assign o_State = r_State;

endmodule

// File: rtl/card_dealer.sv
// Deals cards without replacement from a 52-card deck using an LFSR
// with a bounded linear-scan fallback. Optional: FACE_AS_TEN_EN.
module card_dealer
    import card_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int LFSR_W    = 16,
    parameter int MAX_TRIES = 32
) (
    input  logic             clk_50M,
    input  logic             i_RstCounter,
    input  logic [WIDTH-1:0] i_Seed,
    input  logic             i_LoadSeed,
    input  logic             i_Shuffle,
    input  logic             i_DealReq,
    output logic [3:0]       o_Card,
    output logic             o_CardValid,
    output logic             o_Busy,
    output logic             o_DeckEmpty,
    output logic [5:0]       o_CardsLeft
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    state_t            r_State;
    state_t            w_StateNext;
    logic [LFSR_W-1:0] w_LfsrState;
    logic [LFSR_W-1:0] w_SeedVal;
    logic [3:0]        w_Cand;
    logic [3:0]        w_ScanStartIdx;
    logic [15:0]       w_CountNz;

    logic [2:0]        r_Count [1:13];
    logic [TRY_W-1:0]  r_Tries;
    logic [3:0]        r_ScanIdx;
    logic [3:0]        r_Rank;
    logic [3:0]        r_Card;
    logic              r_CardValid;
    logic              r_Busy;
    logic              r_DeckEmpty;
    logic [5:0]        r_CardsLeft;

    logic              w_Step;
    logic              w_Load;
    logic              w_Shuffle;
    logic              w_Start;
    logic              w_Take;
    logic [3:0]        w_TakeRank;
    logic              w_TryInc;
    logic              w_ScanStart;
    logic              w_ScanAdv;

    always_comb begin
        w_SeedVal = '0;
        w_SeedVal[WIDTH-1:0] = i_Seed;
        w_SeedVal = w_SeedVal ^ LFSR_DEFAULT;
    end

    card_lfsr #(
        .LFSR_W (LFSR_W)
    ) u_lfsr (
        .clk_50M      (clk_50M),
        .i_RstCounter (i_RstCounter),
        .i_Step       (w_Step),
        .i_Load       (w_Load),
        .i_LoadVal    (w_SeedVal),
        .o_State      (w_LfsrState)
    );

    assign w_Cand = next_cand(w_LfsrState);

    // (r mod 13) + 1 for a 4-bit r
    assign w_ScanStartIdx = (w_Cand >= 4'd13) ? (w_Cand - 4'd12)
                                              : (w_Cand + 4'd1);

    // Non-empty flags indexed by raw nibble; 0, 14, 15 are never valid.
    always_comb begin
        w_CountNz = '0;
        for (int i = RANK_MIN; i <= RANK_MAX; i++) begin
            w_CountNz[i] = (r_Count[i] != 3'd0);
        end
    end

    always_ff @(posedge clk_50M or posedge i_RstCounter) begin
        if (i_RstCounter) begin
            r_State <= ST_IDLE;
        end else begin
            r_State <= w_StateNext;
        end
    end

    always_comb begin
        w_StateNext = r_State;
        w_Step      = 1'b0;
        w_Load      = 1'b0;
        w_Shuffle   = 1'b0;
        w_Start     = 1'b0;
        w_Take      = 1'b0;
        w_TakeRank  = 4'd0;
        w_TryInc    = 1'b0;
        w_ScanStart = 1'b0;
        w_ScanAdv   = 1'b0;
        unique case (r_State)
            ST_IDLE: begin
                if (i_Shuffle) begin
                    w_Shuffle = 1'b1;
                end else if (i_LoadSeed) begin
                    w_Load = 1'b1;
                end else if (i_DealReq && !r_DeckEmpty) begin
                    w_Start     = 1'b1;
                    w_StateNext = ST_DRAW;
                end
            end
            ST_DRAW: begin
                w_Step = 1'b1;
                if (w_CountNz[w_Cand]) begin
                    w_Take      = 1'b1;
                    w_TakeRank  = w_Cand;
                    w_StateNext = ST_EMIT;
                end else if (r_Tries == TRY_W'(MAX_TRIES - 1)) begin
                    w_ScanStart = 1'b1;
                    w_StateNext = ST_SCAN;
                end else begin
                    w_TryInc = 1'b1;
                end
            end
            ST_SCAN: begin
                if (w_CountNz[r_ScanIdx]) begin
                    w_Take      = 1'b1;
                    w_TakeRank  = r_ScanIdx;
                    w_StateNext = ST_EMIT;
                end else begin
                    w_ScanAdv = 1'b1;
                end
            end
            ST_EMIT: begin
                w_StateNext = ST_IDLE;
            end
            default: begin
                w_StateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50M or posedge i_RstCounter) begin
        if (i_RstCounter) begin
            for (int i = RANK_MIN; i <= RANK_MAX; i++) begin
                r_Count[i] <= 3'(CARDS_PER_RANK);
            end
        end else begin
            for (int i = RANK_MIN; i <= RANK_MAX; i++) begin
                if (w_Shuffle) begin
                    r_Count[i] <= 3'(CARDS_PER_RANK);
                end else if (w_Take && (w_TakeRank == 4'(i))) begin
                    r_Count[i] <= r_Count[i] - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_50M or posedge i_RstCounter) begin
        if (i_RstCounter) begin
            r_Tries   <= '0;
            r_ScanIdx <= 4'd1;
            r_Rank    <= 4'd0;
        end else begin
            if (w_Start) begin
                r_Tries <= '0;
            end else if (w_TryInc) begin
                r_Tries <= r_Tries + 1'b1;
            end
            if (w_ScanStart) begin
                r_ScanIdx <= w_ScanStartIdx;
            end else if (w_ScanAdv) begin
                r_ScanIdx <= (r_ScanIdx == 4'd13) ? 4'd1
                                                  : (r_ScanIdx + 4'd1);
            end
            if (w_Take) begin
                r_Rank <= w_TakeRank;
            end
        end
    end

    always_ff @(posedge clk_50M or posedge i_RstCounter) begin
        if (i_RstCounter) begin
            r_Card      <= 4'd0;
            r_CardValid <= 1'b0;
            r_Busy      <= 1'b0;
            r_DeckEmpty <= 1'b0;
            r_CardsLeft <= 6'(DECK_SIZE);
        end else begin
            r_CardValid <= 1'b0;
            if (w_Start) begin
                r_Busy <= 1'b1;
            end
            if (w_Shuffle) begin
                r_CardsLeft <= 6'(DECK_SIZE);
                r_DeckEmpty <= 1'b0;
            end
            if (r_State == ST_EMIT) begin
                r_Card      <= rank_to_value(r_Rank);
                r_CardValid <= 1'b1;
                r_Busy      <= 1'b0;
                r_CardsLeft <= r_CardsLeft - 6'd1;
                r_DeckEmpty <= (r_CardsLeft == 6'd1);
            end
        end
    end

    assign o_Card      = r_Card;
    assign o_CardValid = r_CardValid;
    assign o_Busy      = r_Busy;
    assign o_DeckEmpty = r_DeckEmpty;
    assign o_CardsLeft = r_CardsLeft;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer with a reference draw model.
// Honours FACE_AS_TEN_EN when mapping expected card values.
module tb_card_dealer;

    localparam int MAX_TRIES = 32;

    logic        clk_50M;
    logic        i_RstCounter;
    logic [11:0] i_Seed;
    logic        i_LoadSeed;
    logic        i_Shuffle;
    logic        i_DealReq;
    logic [3:0]  o_Card;
    logic        o_CardValid;
    logic        o_Busy;
    logic        o_DeckEmpty;
    logic [5:0]  o_CardsLeft;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr;
    int          m_cnt [1:13];
    int          hist [0:15];
    logic [3:0]  seq_a [0:4];

    card_dealer #(
        .WIDTH     (12),
        .LFSR_W    (16),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk_50M      (clk_50M),
        .i_RstCounter (i_RstCounter),
        .i_Seed       (i_Seed),
        .i_LoadSeed   (i_LoadSeed),
        .i_Shuffle    (i_Shuffle),
        .i_DealReq    (i_DealReq),
        .o_Card       (o_Card),
        .o_CardValid  (o_CardValid),
        .o_Busy       (o_Busy),
        .o_DeckEmpty  (o_DeckEmpty),
        .o_CardsLeft  (o_CardsLeft)
    );

    initial begin
        clk_50M = 1'b0;
        forever #10 clk_50M = ~clk_50M;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_val(input int rank);
`ifdef FACE_AS_TEN_EN
        return (rank > 10) ? 4'd10 : 4'(rank);
`else
        return 4'(rank);
`endif
    endfunction

    function automatic int exp_hist(input int v);
`ifdef FACE_AS_TEN_EN
        if (v == 10) return 16;
        if (v > 10) return 0;
        return 4;
`else
        return 4;
`endif
    endfunction

    function automatic logic [15:0] m_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        for (int i = 1; i <= 13; i++) m_cnt[i] = 4;
    endtask

    task automatic model_deal(output int rank, output int lat);
        int k;
        int r;
        int idx;
        int m;
        bit found;
        k = 0;
        found = 0;
        rank = 0;
        lat = 0;
        r = 0;
        while (!found && k < MAX_TRIES) begin
            m_lfsr = m_step(m_lfsr);
            k++;
            r = int'(m_lfsr[3:0]);
            if (r >= 1 && r <= 13 && m_cnt[(r >= 1 && r <= 13) ? r : 1] > 0) begin
                found = 1;
                rank = r;
                lat = k + 1;
            end
        end
        if (!found) begin
            idx = (r % 13) + 1;
            m = 1;
            while (m_cnt[idx] == 0 && m < 14) begin
                idx = (idx == 13) ? 1 : idx + 1;
                m++;
            end
            rank = idx;
            lat = MAX_TRIES + m + 1;
        end
        m_cnt[rank]--;
    endtask

    task automatic do_reset();
        @(posedge clk_50M);
        #1 i_RstCounter = 1'b1;
        @(posedge clk_50M);
        #1 i_RstCounter = 1'b0;
        model_reset();
    endtask

    task automatic load_seed(input logic [11:0] s);
        logic [15:0] v;
        @(posedge clk_50M);
        #1 i_Seed = s;
        i_LoadSeed = 1'b1;
        @(posedge clk_50M);
        #1 i_LoadSeed = 1'b0;
        v = {4'h0, s} ^ 16'hACE1;
        m_lfsr = (v == 16'h0) ? 16'hACE1 : v;
    endtask

    task automatic do_deal(output logic got, output logic [3:0] card,
                           output int lat, output logic busy1);
        int cnt;
        @(posedge clk_50M);
        #1 i_DealReq = 1'b1;
        @(posedge clk_50M);
        #1 i_DealReq = 1'b0;
        busy1 = o_Busy;
        cnt = 1;
        got = 1'b0;
        card = 4'd0;
        lat = 0;
        while (!got && cnt < 80) begin
            @(posedge clk_50M);
            #1 cnt++;
            if (o_CardValid) begin
                got = 1'b1;
                card = o_Card;
                lat = cnt - 1;
            end
        end
        if (!got) chk("deal_timeout", 0, 1);
    endtask

    // Request pulse, optional second request or reset right after acceptance.
    task automatic req_watch(input logic dup, input logic rst_mid, input int ncyc,
                             output int nvalid, output logic [3:0] card,
                             output logic busy_seen);
        @(posedge clk_50M);
        #1 i_DealReq = 1'b1;
        @(posedge clk_50M);
        #1 i_DealReq = dup;
        busy_seen = o_Busy;
        nvalid = 0;
        card = 4'd0;
        if (rst_mid) i_RstCounter = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk_50M);
            #1 i_DealReq = 1'b0;
            i_RstCounter = 1'b0;
            if (o_CardValid) begin
                nvalid++;
                card = o_Card;
            end
            busy_seen = busy_seen | o_Busy;
        end
    endtask

    initial begin
        logic       got;
        logic [3:0] card;
        logic       busy1;
        int         lat;
        int         rank;
        int         elat;
        int         nv;

        i_RstCounter = 1'b1;
        i_Seed = 12'h0;
        i_LoadSeed = 1'b0;
        i_Shuffle = 1'b0;
        i_DealReq = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_50M);
        #1 i_RstCounter = 1'b0;
        repeat (10) @(posedge clk_50M);
        #1;
        chk("rst_left", int'(o_CardsLeft), 52);
        chk("rst_empty", int'(o_DeckEmpty), 0);
        chk("rst_valid", int'(o_CardValid), 0);
        chk("rst_busy", int'(o_Busy), 0);
        chk("rst_card", int'(o_Card), 0);

        // Whole deck from a fixed seed
        for (int v = 0; v < 16; v++) hist[v] = 0;
        load_seed(12'h5A3);
        for (int i = 0; i < 52; i++) begin
            do_deal(got, card, lat, busy1);
            model_deal(rank, elat);
            chk("deal_got", int'(got), 1);
            chk("deal_card", int'(card), int'(exp_val(rank)));
            chk("deal_lat", lat, elat);
            if (i == 0) chk("busy_draw", int'(busy1), 1);
            hist[card]++;
            if (i == 50) chk("left_one", int'(o_CardsLeft), 1);
            if (i == 51) begin
                chk("lat_bound", int'(lat <= 2 + MAX_TRIES + 13), 1);
                chk("empty_last", int'(o_DeckEmpty), 1);
                chk("left_zero", int'(o_CardsLeft), 0);
            end
        end
        for (int v = 1; v <= 13; v++) chk("hist", hist[v], exp_hist(v));

        req_watch(1'b0, 1'b0, 10, nv, card, busy1);
        chk("empty_no_pulse", nv, 0);
        chk("empty_no_busy", int'(busy1), 0);

        @(posedge clk_50M);
        #1 i_Shuffle = 1'b1;
        @(posedge clk_50M);
        #1 i_Shuffle = 1'b0;
        for (int i = 1; i <= 13; i++) m_cnt[i] = 4;
        chk("shuf_left", int'(o_CardsLeft), 52);
        chk("shuf_empty", int'(o_DeckEmpty), 0);

        // Shuffle outranks a coincident deal request
        do_deal(got, card, lat, busy1);
        model_deal(rank, elat);
        chk("pre_shuf_card", int'(card), int'(exp_val(rank)));
        @(posedge clk_50M);
        #1 i_Shuffle = 1'b1;
        i_DealReq = 1'b1;
        @(posedge clk_50M);
        #1 i_Shuffle = 1'b0;
        i_DealReq = 1'b0;
        for (int i = 1; i <= 13; i++) m_cnt[i] = 4;
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_50M);
            #1 if (o_CardValid) nv++;
        end
        chk("shuf_drop_deal", nv, 0);
        chk("shuf_drop_left", int'(o_CardsLeft), 52);

        // Same seed reproduces the same sequence across reset
        do_reset();
        load_seed(12'h5A3);
        for (int i = 0; i < 5; i++) begin
            do_deal(got, card, lat, busy1);
            model_deal(rank, elat);
            chk("repA_card", int'(card), int'(exp_val(rank)));
            seq_a[i] = card;
        end
        do_reset();
        load_seed(12'h5A3);
        for (int i = 0; i < 5; i++) begin
            do_deal(got, card, lat, busy1);
            model_deal(rank, elat);
            chk("repB_card", int'(card), int'(seq_a[i]));
        end

        // Zero seed collapses onto the reset default state
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_deal(got, card, lat, busy1);
            model_deal(rank, elat);
            chk("dflt_card", int'(card), int'(exp_val(rank)));
            seq_a[i] = card;
        end
        do_reset();
        load_seed(12'h000);
        for (int i = 0; i < 5; i++) begin
            do_deal(got, card, lat, busy1);
            model_deal(rank, elat);
            chk("zero_card", int'(card), int'(seq_a[i]));
        end

        // Request while busy is dropped
        do_reset();
        req_watch(1'b1, 1'b0, 70, nv, card, busy1);
        model_deal(rank, elat);
        chk("busy_one_pulse", nv, 1);
        chk("busy_card", int'(card), int'(exp_val(rank)));
        chk("busy_left", int'(o_CardsLeft), 51);

        // Reset during DRAW
        req_watch(1'b0, 1'b1, 60, nv, card, busy1);
        model_reset();
        chk("rstdraw_pulse", nv, 0);
        chk("rstdraw_left", int'(o_CardsLeft), 52);
        chk("rstdraw_busy", int'(o_Busy), 0);

        do_deal(got, card, lat, busy1);
        model_deal(rank, elat);
        chk("post_rst_card", int'(card), int'(exp_val(rank)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
